data_bus_ctrl: RTL
==================

Name: data_bus_ctrl

Overview:
- Sits directly downstream of the RV32I core's data-memory port.
- Decodes the core's data address into three regions: on-chip data RAM, APB peripheral window, or unmapped.
- RAM accesses complete in the same cycle. Peripheral accesses run an APB master handshake and hold core_stall until completion.
- Returns raw 32-bit read data; the core datapath does load byte/halfword extraction.

Parameters:
- RAM_BASE, 32'h0000_0000, byte base address of data RAM.
- RAM_AW, 10, RAM word-address width (4 KiB).
- PERIPH_BASE, 32'h1000_0000, byte base of the APB window.
- PERIPH_AW, 12, APB byte-offset width (4 KiB window).
- TIMEOUT, 16, max ACCESS-state cycles waiting for PREADY before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- addr  in  32  byte address from core ALU_result
- MemRead  in  1  load request
- MemWrite  in  1  store request
- w_data  in  32  store data, already lane-aligned
- byte_enable  in  4  store byte lanes
- r_data  out  32  load data to core
- core_stall  out  1  core must hold PC/regfile while high
- bus_err  out  1  one-cycle pulse: unmapped access or APB timeout/PSLVERR
- ram_we  out  1  RAM write strobe
- ram_be  out  4  RAM byte enables
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data (combinational read)
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  PERIPH_AW  APB byte offset (addr - PERIPH_BASE)
- PWDATA  out  32;  PSTRB  out  4
- PRDATA  in  32;  PREADY  in  1;  PSLVERR  in  1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, PSEL=PENABLE=PWRITE=0, PADDR/PWDATA/PSTRB=0, rdata capture reg=0, timeout counter=0, bus_err=0.
- Decode is combinational on addr:
  - RAM hit if addr[31:RAM_AW+2]==RAM_BASE[31:RAM_AW+2].
  - PERIPH hit if addr[31:PERIPH_AW]==PERIPH_BASE[31:PERIPH_AW].
  - Otherwise unmapped.
- req = MemRead|MemWrite. If both are asserted, treat as write.
- RAM path, 0 extra latency:
  - ram_addr=addr[RAM_AW+1:2]; ram_be=byte_enable; ram_wdata=w_data.
  - ram_we = MemWrite & RAM hit & state==IDLE.
  - r_data=ram_rdata; core_stall=0.
- Unmapped: r_data=0, writes dropped, bus_err pulses in the request cycle (combinational, IDLE only), core_stall=0.
- APB FSM, states IDLE, SETUP, ACCESS, DONE:
  - IDLE: on req & PERIPH hit -> SETUP. core_stall=1 combinationally in that same cycle. Latch PADDR, PWRITE, PWDATA, PSTRB (PSTRB=0 on reads).
  - SETUP: PSEL=1, PENABLE=0, core_stall=1 -> ACCESS; clear counter.
  - ACCESS: PSEL=1, PENABLE=1, core_stall=1.
    - If PREADY: capture PRDATA (reads only), bus_err next cycle if PSLVERR -> DONE.
    - Else if counter==TIMEOUT-1: capture 32'h0 -> DONE with bus_err pulse.
    - Else counter++.
  - DONE: PSEL=PENABLE=0, core_stall=0, r_data=captured reg; core retires the instruction -> IDLE unconditionally. This prevents the still-present req from retriggering in the same instruction.
- core_stall = (state==IDLE & req & PERIPH hit) | state∈{SETUP, ACCESS}.
- APB outputs stay stable from SETUP through ACCESS regardless of core inputs, which are frozen anyway.
- Reset mid-transaction aborts immediately to IDLE. No completion pulse, no RAM write.
- Counter saturates; it never wraps.

Decomposition:
- Shared package (rv32i_pkg):
  - region enum {REG_RAM, REG_PERIPH, REG_NONE}
  - APB FSM state enum
  - default map constants RAM_BASE and PERIPH_BASE
- Sub-module apb_master: FSM, counter, capture reg, APB outputs.
- Top data_bus_ctrl: address decode, RAM path, output muxing.

Test Plan:
- Store 0xA5A5A5A5 be=4'b1111 to 0x0000_0010, then load from it -> ram_we=1, ram_addr=4 in the store cycle; r_data=0xA5A5A5A5 with core_stall=0 throughout.
- Load 0x1000_0004, PREADY high on first ACCESS, PRDATA=0x12345678 -> stall high 3 cycles (IDLE-req, SETUP, ACCESS), DONE cycle r_data=0x12345678, PADDR=0x004, PWRITE=0.
- Store 0x1000_0008 be=4'b0011 data 0xBEEF, PREADY delayed 3 ACCESS cycles -> PWRITE=1, PSTRB=0011, PWDATA stable, stall for 6 cycles total, ram_we never asserted.
- Load 0x1000_0000 with PREADY tied low, TIMEOUT=16 -> exactly 16 ACCESS cycles, DONE with r_data=0, bus_err one-cycle pulse, FSM back to IDLE.
- Load 0x2000_0000 -> r_data=0, bus_err pulse same cycle, core_stall=0; PSLVERR=1 with PREADY on a peripheral read -> bus_err pulse at DONE.
- Assert rst during ACCESS -> PSEL/PENABLE/core_stall drop asynchronously; next peripheral request starts cleanly from SETUP.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared definitions for the RV32I data-side bus controller.
//   - Default memory map: data RAM at 0x0000_0000, APB window at 0x1000_0000.
//   - region_e    : address-decode result (RAM, APB peripheral, unmapped).
//   - apb_state_e : state of the APB master handshake.
//   - apb_strb()  : APB write strobes; reads always carry PSTRB = 0.
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h1000_0000;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_PERIPH,
    REG_NONE
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } apb_state_e;

  // A read transfer must not drive any strobe lanes.
  function automatic logic [3:0] apb_strb(input logic wr, input logic [3:0] be);
    return wr ? be : 4'b0000;
  endfunction

endpackage

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//   Single-transfer APB master used by data_bus_ctrl. A transfer is started
//   from IDLE by 'start'; the request fields are latched at that point so the
//   APB outputs stay stable through SETUP and ACCESS. ACCESS waits for PREADY
//   for at most TIMEOUT cycles, then aborts with an error. DONE lasts exactly
//   one cycle, during which the captured read data and error flag are valid,
//   and always returns to IDLE so a request still held by the stalled core
//   cannot start a second transfer for the same instruction.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           request to a peripheral address (sampled in IDLE only)
//   wr              1 = write transfer, 0 = read transfer
//   offset          byte offset inside the APB window
//   wdata, be       write data and byte lanes
//   state           current handshake state
//   rdata           captured read data (meaningful in DONE)
//   err             one-cycle error flag, high only in DONE
//   PSEL..PSTRB     APB master outputs
//   PRDATA, PREADY, PSLVERR  APB slave responses
// ---------------------------------------------------------------------------
module apb_master
  import rv32i_pkg::*;
#(
  parameter int unsigned PERIPH_AW = 12,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wr,
  input  logic [PERIPH_AW-1:0] offset,
  input  logic [31:0]          wdata,
  input  logic [3:0]           be,
  output apb_state_e           state,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [PERIPH_AW-1:0] PADDR,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  // Wide enough to hold TIMEOUT itself, so the terminal compare never aliases.
  localparam int unsigned        CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e           state_q,  state_d;
  logic [PERIPH_AW-1:0] paddr_q,  paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic [3:0]           pstrb_q,  pstrb_d;
  logic [31:0]          rdata_q,  rdata_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic                 err_q,    err_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath-register logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case statement; any path
  // that left one unassigned would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETUP;
          paddr_d  = offset;
          pwrite_d = wr;
          pwdata_d = wdata;
          pstrb_d  = apb_strb(wr, be);
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
        err_d   = 1'b0;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          // Write transfers leave the capture register untouched.
          if (!pwrite_q) begin
            rdata_d = PRDATA;
          end
          err_d   = PSLVERR;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Slave never answered: abort with zero data and an error.
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          // Only reached below CNT_LAST, so the counter saturates, never wraps.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state   = state_q;
    PSEL    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    PENABLE = (state_q == ST_ACCESS);
    PWRITE  = pwrite_q;
    PADDR   = paddr_q;
    PWDATA  = pwdata_q;
    PSTRB   = pstrb_q;
    rdata   = rdata_q;
    // The stored flag is only reported during the single DONE cycle.
    err     = (state_q == ST_DONE) && err_q;
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// ---------------------------------------------------------------------------
// data_bus_ctrl
//   Data-side bus controller placed directly after the RV32I core's data
//   memory port. Decodes the byte address into on-chip RAM, the APB
//   peripheral window, or unmapped space.
//   - RAM accesses complete in the request cycle (combinational read data).
//   - Peripheral accesses run an APB transfer and hold core_stall high until
//     the result is available in the DONE cycle.
//   - Unmapped accesses return zero, drop writes and pulse bus_err.
//   Read data is returned as the raw 32-bit word; byte/halfword extraction
//   happens in the core datapath.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   addr                  byte address from the core ALU
//   MemRead, MemWrite     load / store request (both high = store)
//   w_data, byte_enable   lane-aligned store data and byte lanes
//   r_data                load data to the core
//   core_stall            core holds PC and register file while high
//   bus_err               one-cycle error pulse
//   ram_*                 synchronous-write / combinational-read RAM port
//   PSEL..PSLVERR         APB master interface
// ---------------------------------------------------------------------------
module data_bus_ctrl #(
  parameter logic [31:0] RAM_BASE    = rv32i_pkg::RAM_BASE,
  parameter int unsigned RAM_AW      = 10,
  parameter logic [31:0] PERIPH_BASE = rv32i_pkg::PERIPH_BASE,
  parameter int unsigned PERIPH_AW   = 12,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [31:0]          w_data,
  input  logic [3:0]           byte_enable,
  output logic [31:0]          r_data,
  output logic                 core_stall,
  output logic                 bus_err,
  output logic                 ram_we,
  output logic [3:0]           ram_be,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [PERIPH_AW-1:0] PADDR,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  import rv32i_pkg::*;

  region_e              region;
  logic                 req;
  logic                 periph_req;
  logic                 apb_idle;
  logic                 apb_busy;
  logic [PERIPH_AW-1:0] periph_off;
  apb_state_e           apb_state;
  logic [31:0]          apb_rdata;
  logic                 apb_err;

  // ---------------------------------------------------------------------------
  // Address decode. Both bases are aligned to their window size, so a window
  // hit is a compare of the upper address bits only.
  // ---------------------------------------------------------------------------
  always_comb begin
    region = REG_NONE;
    if (addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]) begin
      region = REG_RAM;
    end else if (addr[31:PERIPH_AW] == PERIPH_BASE[31:PERIPH_AW]) begin
      region = REG_PERIPH;
    end
  end

  // A simultaneous MemRead/MemWrite is a store: MemWrite alone selects the
  // direction everywhere below.
  assign req        = MemRead | MemWrite;
  assign periph_req = req && (region == REG_PERIPH);

  // The window base is aligned, so addr - PERIPH_BASE is just the low bits.
  assign periph_off = addr[PERIPH_AW-1:0];

  // ---------------------------------------------------------------------------
  // APB master
  // ---------------------------------------------------------------------------
  apb_master #(
    .PERIPH_AW (PERIPH_AW),
    .TIMEOUT   (TIMEOUT)
  ) u_apb_master (
    .clk     (clk),
    .rst     (rst),
    .start   (periph_req),
    .wr      (MemWrite),
    .offset  (periph_off),
    .wdata   (w_data),
    .be      (byte_enable),
    .state   (apb_state),
    .rdata   (apb_rdata),
    .err     (apb_err),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  assign apb_idle = (apb_state == ST_IDLE);
  assign apb_busy = (apb_state == ST_SETUP) || (apb_state == ST_ACCESS);

  // ---------------------------------------------------------------------------
  // RAM port: address, lanes and data go straight through; only the write
  // strobe is qualified. Gating with IDLE keeps a store from landing in RAM
  // while the controller is finishing a peripheral transfer.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr  = addr[RAM_AW+1:2];
    ram_be    = byte_enable;
    ram_wdata = w_data;
    ram_we    = MemWrite && (region == REG_RAM) && apb_idle;
  end

  // ---------------------------------------------------------------------------
  // Core-facing outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // The stall rises combinationally in the request cycle so the core does
    // not retire a peripheral access before SETUP has even started.
    core_stall = (apb_idle && periph_req) || apb_busy;

    // Unmapped accesses are flagged immediately; APB errors arrive in DONE.
    bus_err = apb_err || (apb_idle && req && (region == REG_NONE));

    if (apb_state == ST_DONE) begin
      r_data = apb_rdata;
    end else if (region == REG_RAM) begin
      r_data = ram_rdata;
    end else begin
      r_data = '0;
    end
  end

endmodule
